// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Requester index constants name the ports fixed by the pipeline; higher indices are spare ports.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } arb_state_e;

  localparam int REQ_FETCH       = 0;
  localparam int REQ_LOAD        = 1;
  localparam int REQ_STORE       = 2;
  localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int GIDX_W  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GIDX_W-1:0]  ptr,
  output logic               any_valid,
  output logic [GIDX_W-1:0]  winner
);

  // Scan from the farthest offset down so the nearest hit is the last one written.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        any_valid = 1'b1;
        winner    = GIDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of NUM_REQ requesters onto one single-ported data memory.
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no transaction; arbitrate and register winner
// ST_READ  | read enable high, wait for mem_output_valid_in
// ST_WRITE | write enable high, wait for mem_write_ready_in
// 2'b11    | illegal, recovers to ST_IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int GIDX_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid_in,
  input  logic [NUM_REQ-1:0] req_write_in,
  input  logic               mem_output_valid_in,
  input  logic               mem_write_ready_in,
  output logic [GIDX_W-1:0]  addr_select_out,
  output logic               mem_read_en_out,
  output logic               mem_write_en_out,
  output logic [NUM_REQ-1:0] done_out,
  output logic [NUM_REQ-1:0] stall_out,
  output logic               timeout_err_out,
  output logic [1:0]         state
);

  arb_state_e        st_q, st_d;
  logic [GIDX_W-1:0] grant_q, grant_d;
  logic [GIDX_W-1:0] ptr_q, ptr_d;
  logic              any_valid;
  logic [GIDX_W-1:0] winner;
  logic              busy;
  logic              rsp;
  logic              tmo_hit;
  logic              complete;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GIDX_W  (GIDX_W)
  ) u_rr (
    .req       (req_valid_in),
    .ptr       (ptr_q),
    .any_valid (any_valid),
    .winner    (winner)
  );

  assign busy = (st_q == ST_READ) || (st_q == ST_WRITE);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt_q;

  // Held at zero outside a transaction, so it starts from zero on every grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    cnt_q <= '0;
    else if (busy) cnt_q <= cnt_q + 1'b1;
    else           cnt_q <= '0;
  end

  assign tmo_hit         = busy && (cnt_q == CNT_W'(TIMEOUT_CYC));
  assign timeout_err_out = tmo_hit && !rsp;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign tmo_hit            = 1'b0;
  assign timeout_err_out    = 1'b0;
`endif

  assign complete = rsp || tmo_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q    <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      st_q    <= st_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    rsp     = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_d = winner;
          st_d    = req_write_in[winner] ? ST_WRITE : ST_READ;
        end
      end
      ST_READ:  rsp = mem_output_valid_in;
      ST_WRITE: rsp = mem_write_ready_in;
      default:  st_d = ST_IDLE;
    endcase
    // Explicit wrap keeps non-power-of-two configurations off nonexistent indices.
    if (busy && complete) begin
      st_d  = ST_IDLE;
      ptr_d = (grant_q == GIDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  always_comb begin
    mem_read_en_out  = (st_q == ST_READ);
    mem_write_en_out = (st_q == ST_WRITE);
    addr_select_out  = busy ? grant_q : '0;
    done_out         = '0;
    if (busy && complete) done_out = NUM_REQ'(1) << grant_q;
  end

  assign stall_out = req_valid_in & ~done_out;
  assign state     = st_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (NUM_REQ = 3, TIMEOUT_CYC = 4).
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] req_valid_in;
  logic [2:0] req_write_in;
  logic       mem_output_valid_in;
  logic       mem_write_ready_in;
  logic [1:0] addr_select_out;
  logic       mem_read_en_out;
  logic       mem_write_en_out;
  logic [2:0] done_out;
  logic [2:0] stall_out;
  logic       timeout_err_out;
  logic [1:0] state;

  int errs   = 0;
  int checks = 0;

  mem_port_arbiter #(
    .NUM_REQ     (3),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid_in        (req_valid_in),
    .req_write_in        (req_write_in),
    .mem_output_valid_in (mem_output_valid_in),
    .mem_write_ready_in  (mem_write_ready_in),
    .addr_select_out     (addr_select_out),
    .mem_read_en_out     (mem_read_en_out),
    .mem_write_en_out    (mem_write_en_out),
    .done_out            (done_out),
    .stall_out           (stall_out),
    .timeout_err_out     (timeout_err_out),
    .state               (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One granted transaction already in READ/WRITE: raise the response, check done, complete.
  task automatic finish_txn(input string tag, input logic is_write, input logic [2:0] exp_done);
    mem_output_valid_in = !is_write;
    mem_write_ready_in  = is_write;
    #1;
    chk({tag, "_done"}, 32'(done_out), 32'(exp_done));
    step();
    mem_output_valid_in = 1'b0;
    mem_write_ready_in  = 1'b0;
    chk({tag, "_idle"}, 32'(state), 32'(ST_IDLE));
    chk({tag, "_done_clr"}, 32'(done_out), 32'd0);
  endtask

  logic saw_tmo;

  initial begin
    reset               = 1'b0;
    req_valid_in        = 3'b111;
    req_write_in        = 3'b100;
    mem_output_valid_in = 1'b0;
    mem_write_ready_in  = 1'b0;
    #12;
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_rd_en", 32'(mem_read_en_out), 32'd0);
    chk("rst_wr_en", 32'(mem_write_en_out), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'b111);
    chk("rst_addr", 32'(addr_select_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_tmo", 32'(timeout_err_out), 32'd0);

    // Rotation with all three requesting; requester 2 stores.
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("g0_state", 32'(state), 32'(ST_READ));
    chk("g0_rd_en", 32'(mem_read_en_out), 32'd1);
    chk("g0_addr", 32'(addr_select_out), 32'(REQ_FETCH));
    chk("g0_stall", 32'(stall_out), 32'b111);
    mem_output_valid_in = 1'b1;
    #1;
    chk("g0_stall_done", 32'(stall_out), 32'b110);
    mem_output_valid_in = 1'b0;
    finish_txn("g0", 1'b0, 3'b001);
    chk("g0_bubble_addr", 32'(addr_select_out), 32'd0);
    step();
    chk("g1_state", 32'(state), 32'(ST_READ));
    chk("g1_addr", 32'(addr_select_out), 32'(REQ_LOAD));
    finish_txn("g1", 1'b0, 3'b010);
    step();
    chk("g2_state", 32'(state), 32'(ST_WRITE));
    chk("g2_wr_en", 32'(mem_write_en_out), 32'd1);
    chk("g2_rd_en", 32'(mem_read_en_out), 32'd0);
    chk("g2_addr", 32'(addr_select_out), 32'(REQ_STORE));
    mem_output_valid_in = 1'b1;
    #1;
    chk("g2_ignore_done", 32'(done_out), 32'd0);
    step();
    chk("g2_ignore_state", 32'(state), 32'(ST_WRITE));
    finish_txn("g2", 1'b1, 3'b100);
    step();
    chk("g3_addr", 32'(addr_select_out), 32'd0);
    chk("g3_state", 32'(state), 32'(ST_READ));
    finish_txn("g3", 1'b0, 3'b001);

    // Only requester 1: first from pointer 1, then from pointer 2 (wrap).
    req_valid_in = 3'b010;
    step();
    chk("s1a_addr", 32'(addr_select_out), 32'd1);
    finish_txn("s1a", 1'b0, 3'b010);
    step();
    chk("s1b_wrap_addr", 32'(addr_select_out), 32'd1);
    chk("s1b_state", 32'(state), 32'(ST_READ));
    finish_txn("s1b", 1'b0, 3'b010);
    req_valid_in = 3'b111;
    step();
    chk("ptr2_addr", 32'(addr_select_out), 32'd2);
    chk("ptr2_state", 32'(state), 32'(ST_WRITE));
    finish_txn("ptr2", 1'b1, 3'b100);

    // Requester 0 withdraws mid-read: still completes, pointer moves to 1.
    req_valid_in = 3'b001;
    step();
    chk("drop_addr", 32'(addr_select_out), 32'd0);
    req_valid_in = 3'b000;
    step();
    chk("drop_state", 32'(state), 32'(ST_READ));
    chk("drop_stall", 32'(stall_out), 32'b000);
    finish_txn("drop", 1'b0, 3'b001);
    req_valid_in = 3'b011;
    step();
    chk("drop_next_addr", 32'(addr_select_out), 32'd1);
    finish_txn("drop_next", 1'b0, 3'b010);

    // Reset asserted during a stalled write.
    req_valid_in = 3'b100;
    step();
    chk("rw_state", 32'(state), 32'(ST_WRITE));
    chk("rw_wr_en", 32'(mem_write_en_out), 32'd1);
    reset = 1'b0;
    #1;
    chk("rw_wr_en_async", 32'(mem_write_en_out), 32'd0);
    chk("rw_state_async", 32'(state), 32'(ST_IDLE));
    chk("rw_done", 32'(done_out), 32'd0);
    chk("rw_addr", 32'(addr_select_out), 32'd0);
    req_valid_in = 3'b000;
    step();
    reset = 1'b1;
    step();
    chk("rw_post_state", 32'(state), 32'(ST_IDLE));

    // Silent memory on a read from requester 0.
    req_valid_in = 3'b001;
    req_write_in = 3'b000;
    step();
    chk("to_state", 32'(state), 32'(ST_READ));
    req_valid_in = 3'b000;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 0; k <= 4; k++) begin
      chk($sformatf("to_err_%0d", k), 32'(timeout_err_out), (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("to_done_%0d", k), 32'(done_out), (k == 4) ? 32'b001 : 32'd0);
      step();
    end
    chk("to_idle", 32'(state), 32'(ST_IDLE));
    chk("to_err_clr", 32'(timeout_err_out), 32'd0);
`else
    saw_tmo = 1'b0;
    for (int k = 0; k < 120; k++) begin
      if (timeout_err_out !== 1'b0 || done_out !== 3'b000) saw_tmo = 1'b1;
      step();
    end
    chk("nto_state", 32'(state), 32'(ST_READ));
    chk("nto_rd_en", 32'(mem_read_en_out), 32'd1);
    chk("nto_no_abort", 32'(saw_tmo), 32'd0);
    finish_txn("nto", 1'b0, 3'b001);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
